// File: rtl/board_link_pkg.sv
// Shared state encodings for the board_link transmitter and receiver.
// Pure types: no latency or flow-control behaviour of its own.
package board_link_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_DATA,
    TX_PARITY,
    TX_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SAMPLE,
    RX_WAIT_LOW
  } rx_state_t;

endpackage

// File: rtl/board_link_rx.sv
// Frame receiver: synchronises bs_in/sig_in, mid-bit samples LSB first, checks even parity.
// Result pulses one cycle after the last sample; no backpressure, rx_data holds the last good payload.
module board_link_rx
  import board_link_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BIT_TICKS = 100,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bs_in,
  input  logic             sig_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic             rx_busy
);

  localparam int N      = WIDTH + PARITY_EN;
  localparam int TICK_W = $clog2(BIT_TICKS);
  localparam int CNT_W  = $clog2(N + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] PRELOAD   = TICK_W'(BIT_TICKS - BIT_TICKS / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);

  logic              bs_s1, bs_s2, sig_s1, sig_s2;
  logic [1:0]        settle;
  logic              armed, armed_nxt;
  rx_state_t         state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [N-1:0]      shift, shift_nxt;
  logic              chk_pend, chk_nxt;
  logic [WIDTH-1:0]  data_nxt;
  logic              valid_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bs_s1    <= 1'b0;
      bs_s2    <= 1'b0;
      sig_s1   <= 1'b0;
      sig_s2   <= 1'b0;
      settle   <= 2'b00;
      armed    <= 1'b0;
      state    <= RX_IDLE;
      tick     <= '0;
      cnt      <= '0;
      shift    <= '0;
      chk_pend <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      bs_s1    <= bs_in;
      bs_s2    <= bs_s1;
      sig_s1   <= sig_in;
      sig_s2   <= sig_s1;
      settle   <= {settle[0], 1'b1};
      armed    <= armed_nxt;
      state    <= state_nxt;
      tick     <= tick_nxt;
      cnt      <= cnt_nxt;
      shift    <= shift_nxt;
      chk_pend <= chk_nxt;
      rx_data  <= data_nxt;
      rx_valid <= valid_nxt;
      rx_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    chk_nxt   = 1'b0;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    // Only arm once the synchronisers hold real input and sig has been seen low,
    // so a frame already running when reset releases is skipped.
    armed_nxt = armed | (settle[1] & ~sig_s2);

    if (chk_pend) begin
      if ((PARITY_EN == 0) || ((^shift) == 1'b0)) begin
        valid_nxt = 1'b1;
        data_nxt  = shift[WIDTH-1:0];
      end else begin
        err_nxt = 1'b1;
      end
    end

    case (state)
      RX_IDLE: begin
        if (armed && sig_s2) begin
          state_nxt = RX_SAMPLE;
          tick_nxt  = PRELOAD;
          cnt_nxt   = '0;
        end
      end
      RX_SAMPLE: begin
        if (!sig_s2) begin
          err_nxt   = 1'b1;
          state_nxt = RX_IDLE;
        end else if (tick == TICK_LAST) begin
          tick_nxt  = '0;
          shift_nxt = {bs_s2, shift[N-1:1]};
          if (cnt == CNT_LAST) begin
            state_nxt = RX_WAIT_LOW;
            chk_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          tick_nxt = tick + TICK_W'(1);
        end
      end
      RX_WAIT_LOW: begin
        if (!sig_s2) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

// File: rtl/board_link.sv
// Board-to-board serial link: inline frame transmitter plus board_link_rx receiver, full duplex.
// TX frame period (WIDTH+PARITY_EN+1)*BIT_TICKS cycles incl. accept; tx_ready low while busy, RX never stalls.
module board_link
  import board_link_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BIT_TICKS = 100,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             bs_out,
  output logic             sig_out,
  input  logic             bs_in,
  input  logic             sig_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic             rx_busy
);

  localparam int TICK_W = $clog2(BIT_TICKS);
  localparam int IDX_W  = $clog2(WIDTH + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(BIT_TICKS - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  tx_state_t         tx_state, tx_state_nxt;
  logic [TICK_W-1:0] tx_tick, tx_tick_nxt;
  logic [IDX_W-1:0]  tx_idx, tx_idx_nxt;
  logic [WIDTH-1:0]  tx_shift, tx_shift_nxt;
  logic              tx_par, tx_par_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_tick  <= tx_tick_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tick_nxt  = tx_tick;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_ready     = 1'b0;
    bs_out       = 1'b0;
    sig_out      = 1'b0;

    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_state_nxt = TX_DATA;
          tx_shift_nxt = tx_data;
          tx_par_nxt   = ^tx_data;
          tx_tick_nxt  = '0;
          tx_idx_nxt   = '0;
        end
      end
      TX_DATA: begin
        sig_out = 1'b1;
        bs_out  = tx_shift[0];
        if (tx_tick == TICK_LAST) begin
          tx_tick_nxt = '0;
          if (tx_idx == IDX_LAST) begin
            tx_state_nxt = (PARITY_EN != 0) ? TX_PARITY : TX_GAP;
          end else begin
            tx_shift_nxt = tx_shift >> 1;
            tx_idx_nxt   = tx_idx + IDX_W'(1);
          end
        end else begin
          tx_tick_nxt = tx_tick + TICK_W'(1);
        end
      end
      TX_PARITY: begin
        sig_out = 1'b1;
        bs_out  = tx_par;
        if (tx_tick == TICK_LAST) begin
          tx_tick_nxt  = '0;
          tx_state_nxt = TX_GAP;
        end else begin
          tx_tick_nxt = tx_tick + TICK_W'(1);
        end
      end
      TX_GAP: begin
        // GAP runs one tick short: the IDLE cycle that accepts the next
        // request is the final low cycle, so back-to-back gaps are BIT_TICKS.
        if (tx_tick == GAP_LAST) begin
          tx_tick_nxt  = '0;
          tx_state_nxt = TX_IDLE;
        end else begin
          tx_tick_nxt = tx_tick + TICK_W'(1);
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  board_link_rx #(
    .WIDTH     (WIDTH),
    .BIT_TICKS (BIT_TICKS),
    .PARITY_EN (PARITY_EN)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .bs_in    (bs_in),
    .sig_in   (sig_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy)
  );

endmodule

// File: tb/tb_board_link.sv
// Bench for board_link: 16-bit/parity link with switchable loopback, plus an 8-bit no-parity loopback link.
// Expected payloads are queued at acceptance and popped when rx_valid fires.
module tb_board_link;

  localparam int W     = 16;
  localparam int BT    = 100;
  localparam int FRAME = (W + 1) * BT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, bs_out, sig_out;
  logic        loop_en, tb_bs, tb_sig, bs_in, sig_in;
  logic [15:0] rx_data;
  logic        rx_valid, rx_err, rx_busy;

  assign bs_in  = loop_en ? bs_out  : tb_bs;
  assign sig_in = loop_en ? sig_out : tb_sig;

  board_link #(.WIDTH(16), .BIT_TICKS(100), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bs_out(bs_out), .sig_out(sig_out), .bs_in(bs_in), .sig_in(sig_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .rx_busy(rx_busy)
  );

  logic [7:0] b_tx_data, b_rx_data;
  logic       b_tx_valid, b_tx_ready, b_bs, b_sig, b_rx_valid, b_rx_err, b_rx_busy;

  board_link #(.WIDTH(8), .BIT_TICKS(4), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .bs_out(b_bs), .sig_out(b_sig), .bs_in(b_bs), .sig_in(b_sig),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_err(b_rx_err), .rx_busy(b_rx_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards
  logic [15:0] sb_q[$];
  logic [7:0]  sb_b[$];
  int          err_exp = 0;
  logic [15:0] last_good;
  logic [15:0] exp_a;
  logic [7:0]  exp_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (sb_q.size() == 0) check("rx_valid_unexpected", rx_valid, 0);
        else begin
          exp_a = sb_q.pop_front();
          check("rx_data", rx_data, exp_a);
        end
      end
      if (rx_err) begin
        if (err_exp == 0) check("rx_err_unexpected", rx_err, 0);
        else begin
          err_exp--;
          check("rx_err_without_valid", rx_valid, 0);
        end
      end
      if (b_rx_valid) begin
        if (sb_b.size() == 0) check("b_rx_valid_unexpected", b_rx_valid, 0);
        else begin
          exp_b = sb_b.pop_front();
          check("b_rx_data", b_rx_data, exp_b);
        end
      end
      if (b_rx_err) check("b_rx_err", b_rx_err, 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int limit);
    int i = 0;
    while (!tx_ready && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!tx_ready) check("tx_ready_timeout", tx_ready, 1);
  endtask

  // Loopback frame on link A; checks line timing and mid-bit values against data/parity.
  task automatic send_frame_a(input logic [15:0] data, input logic par);
    int   sig_hi = 0, busy = 0, bad = 0;
    logic exp_bit;
    wait_ready(4000);
    tx_data  = data;
    tx_valid = 1'b1;
    sb_q.push_back(data);
    last_good = data;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~data;
    for (int k = 0; k < 4000 && !tx_ready; k++) begin
      if (sig_out) sig_hi++;
      busy++;
      if ((k % BT) == BT / 2 && k < FRAME) begin
        exp_bit = (k / BT < W) ? data[k / BT] : par;
        if (bs_out !== exp_bit) bad++;
      end
      @(negedge clk);
    end
    check("sig_high_cycles", sig_hi, FRAME);
    // Frame period of 1800 cycles = accepting cycle + 1799 busy cycles.
    check("tx_busy_cycles", busy, FRAME + BT - 1);
    check("bs_out_bits", bad, 0);
  endtask

  // Bench-driven frame into link A's receiver; bits[0] goes first.
  task automatic drive_bits(input logic [16:0] bits, input int nbits);
    tb_sig = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      tb_bs = bits[b];
      repeat (BT) @(negedge clk);
    end
    tb_sig = 1'b0;
    tb_bs  = 1'b0;
    repeat (2 * BT) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] data;
    logic        par;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   low, busy_cnt, sig_hi, busy;
    logic done, acc2;

    vecs[0] = '{16'hA5C3, 1'b0};
    vecs[1] = '{16'h1234, 1'b1};
    vecs[2] = '{16'h8001, 1'b0};
    vecs[3] = '{16'h0007, 1'b1};
    vecs[4] = '{16'hFFFE, 1'b1};

    rst        = 1'b1;
    loop_en    = 1'b1;
    tb_bs      = 1'b0;
    tb_sig     = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    b_tx_data  = '0;
    b_tx_valid = 1'b0;
    last_good  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_bs_out", bs_out, 0);
    check("rst_sig_out", sig_out, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_rx_busy", rx_busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) send_frame_a(vecs[v].data, vecs[v].par);

    // Back-to-back with tx_valid held; tx_data moves to the second payload right after the first accept.
    wait_ready(4000);
    tx_data  = 16'hFFFF;
    tx_valid = 1'b1;
    sb_q.push_back(16'hFFFF);
    @(negedge clk);
    tx_data = 16'h0000;
    low  = 0;
    done = 1'b0;
    acc2 = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (acc2 && tx_valid) tx_valid = 1'b0;
      if (tx_ready && tx_valid) begin
        sb_q.push_back(16'h0000);
        acc2 = 1'b1;
      end
      if (!sig_out) low++;
      else if (low != 0) done = 1'b1;
      if (!done) @(negedge clk);
    end
    check("b2b_done", done, 1);
    check("b2b_gap_cycles", low, BT);
    check("b2b_second_accepted", acc2, 1);
    tx_valid  = 1'b0;
    last_good = 16'h0000;
    repeat (2) @(negedge clk);
    wait_ready(4000);

    // Reset in the middle of bit 8 of a loopback frame.
    tx_data  = 16'h3C3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (8 * BT + 50 - 1) @(negedge clk);
    check("pre_rst_sig_out", sig_out, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sig_out", sig_out, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_busy", rx_busy, 0);
    check("midrst_rx_data", rx_data, 0);
    rst = 1'b0;
    last_good = 16'h0000;
    repeat (3 * BT) @(negedge clk);
    send_frame_a(16'h0F0F, 1'b0);
    repeat (10) @(negedge clk);

    // Parity error: 0x0001 carries one set bit, so parity bit 0 is wrong.
    loop_en = 1'b0;
    err_exp++;
    drive_bits({1'b0, 16'h0001}, 17);
    check("perr_rx_data_kept", rx_data, last_good);
    check("perr_seen", err_exp, 0);

    // Truncated after 5 of 17 bits, then a clean frame.
    err_exp++;
    drive_bits({1'b1, 16'h1234}, 5);
    check("trunc_seen", err_exp, 0);
    check("trunc_rx_idle", rx_busy, 0);
    sb_q.push_back(16'h1234);
    drive_bits({1'b1, 16'h1234}, 17);
    check("clean_after_trunc", sb_q.size(), 0);

    // Reset while a peer frame is in flight: it must be ignored until sig drops.
    tb_sig = 1'b1;
    tb_bs  = 1'b1;
    repeat (3 * BT) @(negedge clk);
    check("peer_busy_before_rst", rx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 6 * BT; i++) begin
      if (rx_busy) busy_cnt++;
      @(negedge clk);
    end
    check("ignore_inflight_frame", busy_cnt, 0);
    tb_sig = 1'b0;
    tb_bs  = 1'b0;
    repeat (BT) @(negedge clk);
    sb_q.push_back(16'h00FF);
    drive_bits({1'b0, 16'h00FF}, 17);
    check("frame_after_rst", sb_q.size(), 0);
    check("rx_data_after_rst", rx_data, 16'h00FF);
    loop_en = 1'b1;

    // Link B: 8 data bits, no parity, 4 ticks per bit.
    for (int v = 0; v < 2; v++) begin
      b_tx_data  = (v == 0) ? 8'h5A : 8'hC3;
      for (int i = 0; i < 100 && !b_tx_ready; i++) @(negedge clk);
      check("b_tx_ready", b_tx_ready, 1);
      b_tx_valid = 1'b1;
      sb_b.push_back(b_tx_data);
      @(negedge clk);
      b_tx_valid = 1'b0;
      sig_hi = 0;
      busy   = 0;
      for (int k = 0; k < 200 && !b_tx_ready; k++) begin
        if (b_sig) sig_hi++;
        busy++;
        @(negedge clk);
      end
      check("b_sig_high_cycles", sig_hi, 32);
      check("b_tx_busy_cycles", busy, 35);
      repeat (10) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    check("sb_a_left", sb_q.size(), 0);
    check("sb_b_left", sb_b.size(), 0);
    check("err_left", err_exp, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
